alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Instruction sequencer and register file that drives the 4-bit ALU as its initiator.
- Accepts register-to-register instructions through a valid/ready handshake.
- Reads source registers and presents `alu_op` and operands to the ALU.
- Captures the ALU's registered result, flags and write-enable one clock later, then writes the result back.
- Sits between the instruction source and the ALU; owns the architectural register file.

## Interface
Parameters:
- `REG_AW`, default 2: register address width, giving 2^REG_AW registers of 4 bits. Instruction width is `4 + 3*REG_AW`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr_valid`  in  1  instruction offered.
- `instr_ready`  out  1  sequencer can accept.
- `instr`  in  4+3*REG_AW  fields `{op[3:0], rd, rs1, rs2}`, MSB first.
- `alu_operand1`  out  4  to ALU `operand1`.
- `alu_operand2`  out  4  to ALU `operand2`.
- `alu_op`  out  4  to ALU `alu_op`.
- `alu_result`  in  4  from ALU `result`.
- `alu_zero`  in  1  from ALU `zero_flag`.
- `alu_carry`  in  1  from ALU `carry_flag`.
- `alu_we`  in  1  from ALU `write_enable`.
- `done`  out  1  one-cycle pulse per retired instruction.
- `z_flag`  out  1  registered zero flag of the last ALU instruction.
- `c_flag`  out  1  registered carry flag of the last ALU instruction.
- `dbg_addr`  in  REG_AW  debug read address.
- `dbg_data`  out  4  combinational read of `regs[dbg_addr]`.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE.
  - IDLE: `instr_ready=1`. On `instr_valid` go to ISSUE.
    - At that edge, latch `op` into `alu_op`, `regs[rs1]` into `alu_operand1`, `regs[rs2]` into `alu_operand2`, and `rd` into an internal register.
  - ISSUE: `instr_ready=0`; operands and `alu_op` held stable. The ALU registers at the end of this cycle. Always go to CAPTURE.
  - CAPTURE: `instr_ready=0`. At the closing edge:
    - If `alu_we=1`, write `regs[rd_q] <= alu_result`.
    - Always load `z_flag <= alu_zero` and `c_flag <= alu_carry`.
    - Set `done` for the next cycle; set `alu_op <= 4'b1111` (idle opcode, which makes the ALU deassert write-enable); go to IDLE.
- Undefined opcodes (1011–1110) are forwarded to the ALU. The ALU returns `alu_we=0`, so there is no register write, but flags still update (ALU gives result 0, zero=1) and `done` still pulses.
- Read-after-write: an instruction accepted in the `done` cycle reads the freshly written value. The write lands at the edge entering that cycle, so no bypass is needed.
- `rd` may equal `rs1` or `rs2`; sources are latched at accept, so there is no hazard.
- Reset mid-instruction, asserted asynchronously, clears everything:
  - state to IDLE, all registers and flags to 0, `done` to 0, operand outputs to 0, `alu_op` to 4'b1111.
  - No write-back of the aborted instruction. Stale ALU outputs are ignored until the next CAPTURE.

## Timing
- Reset values:
  - `instr_ready=1` (combinational from IDLE).
  - `alu_operand1=0`, `alu_operand2=0`, `alu_op=4'b1111`.
  - `done=0`, `z_flag=0`, `c_flag=0`, all registers 0.
- Accept at edge E0 → ISSUE during E0–E1 → ALU outputs valid during E1–E2 (CAPTURE) → write and flags visible, `done=1`, during E2–E3.
- Throughput: one instruction per 3 cycles. A new accept is allowed in the `done` cycle.
- `dbg_data` reflects a write in the cycle after the write edge.

## Configuration
- With `ALU_SEQ_LOADI_EN` defined:
  - Opcode 4'b1111 is a local load-immediate. `{rs1,rs2}[3:0]` is the immediate, taken from the low 4 bits.
  - Accept → CAPTURE directly, skipping ISSUE; the ALU is not used.
  - Writes `regs[rd] <= imm`; flags unchanged; `done` pulses 2 cycles after accept.
- Without the macro: 4'b1111 is treated as an undefined ALU opcode (no write, flags update, 3-cycle latency).

## Structure
- Package `alu_seq_pkg` holds:
  - opcode localparams: ADD=0, SUB=1, MUL=2, DIV=3, AND=4, OR=5, XOR=6, XNOR=7, NOT=8, SHR=9, SHL=10, IDLE/LOADI=15;
  - FSM state enum;
  - instruction field offset functions of `REG_AW`.
- Sub-module `alu_seq_regfile`:
  - 2 combinational read ports plus a debug read port;
  - 1 synchronous write port;
  - async reset to 0.

## Test plan
- Reset, then ADD r0,r1,r2 with r1=4'd9, r2=4'd8 (preloaded via LOADI or force) → `done` 3 cycles after accept; r0=4'h1, `c_flag=1`, `z_flag=0`.
- SUB r3,r1,r1 with r1=5 → r3=0, `z_flag=1`, `c_flag=0`.
- DIV r0,r1,r2 with r2=0 → r0=0, `z_flag=1`. Then opcode 4'b1011 → r0 unchanged, `done` pulses.
- Back-to-back: `instr_valid` held high with two instructions, the second reading the first's `rd` → second accepted in the `done` cycle and uses the new value; `instr_ready` low for exactly 2 cycles per instruction.
- Assert `rst_n` low during CAPTURE of MUL r2 → r2 stays 0, `done` never pulses, `alu_op=4'b1111`, `instr_ready=1` immediately.
- With `ALU_SEQ_LOADI_EN`: LOADI r1,#4'hA → r1=4'hA, `done` 2 cycles after accept, flags unchanged, `alu_op` stays 4'b1111.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state type and instruction field layout for the ALU sequencer.
// The instruction word is {op[3:0], rd, rs1, rs2}, with the op field in the top bits.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_MUL   = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_XNOR  = 4'd7;
  localparam logic [3:0] OP_NOT   = 4'd8;
  localparam logic [3:0] OP_SHR   = 4'd9;
  localparam logic [3:0] OP_SHL   = 4'd10;
  localparam logic [3:0] OP_IDLE  = 4'd15;
  localparam logic [3:0] OP_LOADI = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } seq_state_t;

  function automatic int unsigned instr_width(input int unsigned aw);
    return 4 + 3 * aw;
  endfunction

  function automatic int unsigned op_lsb(input int unsigned aw);
    return 3 * aw;
  endfunction

  function automatic int unsigned rd_lsb(input int unsigned aw);
    return 2 * aw;
  endfunction

  function automatic int unsigned rs1_lsb(input int unsigned aw);
    return aw;
  endfunction

  function automatic int unsigned rs2_lsb(input int unsigned aw);
    return (aw > 0) ? 0 : 0;
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// Architectural register file: 2^AW entries of 4 bits, two operand read ports,
// one debug read port, and a single synchronous write port.
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int unsigned AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    wdata,
  input  logic [AW-1:0] raddr1,
  output logic [3:0]    rdata1,
  input  logic [AW-1:0] raddr2,
  output logic [3:0]    rdata2,
  input  logic [AW-1:0] dbg_addr,
  output logic [3:0]    dbg_data
);

  localparam int unsigned NREG = 1 << AW;

  logic [3:0] regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1   = regs[raddr1];
  assign rdata2   = regs[raddr2];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Instruction sequencer driving a registered 4-bit ALU and owning the register file.
// Optional feature: define ALU_SEQ_LOADI_EN to make opcode 4'b1111 a local load-immediate.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int unsigned REG_AW = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           instr_valid,
  output logic                           instr_ready,
  input  logic [instr_width(REG_AW)-1:0] instr,
  output logic [3:0]                     alu_operand1,
  output logic [3:0]                     alu_operand2,
  output logic [3:0]                     alu_op,
  input  logic [3:0]                     alu_result,
  input  logic                           alu_zero,
  input  logic                           alu_carry,
  input  logic                           alu_we,
  output logic                           done,
  output logic                           z_flag,
  output logic                           c_flag,
  input  logic [REG_AW-1:0]              dbg_addr,
  output logic [3:0]                     dbg_data
);

  localparam int unsigned OP_LSB  = op_lsb(REG_AW);
  localparam int unsigned RD_LSB  = rd_lsb(REG_AW);
  localparam int unsigned RS1_LSB = rs1_lsb(REG_AW);
  localparam int unsigned RS2_LSB = rs2_lsb(REG_AW);

  seq_state_t        state, state_nxt;
  logic [3:0]        f_op;
  logic [REG_AW-1:0] f_rd, f_rs1, f_rs2;
  logic              accept, in_capture, is_loadi;
  logic              rf_we;
  logic [3:0]        rf_wdata, rdata1, rdata2;
  logic [REG_AW-1:0] rd_q;
  logic [3:0]        op_q, opnd1_q, opnd2_q;
  logic              done_q, z_q, c_q;
  logic              loadi_q;
  logic [3:0]        imm_q;

  assign f_op  = instr[OP_LSB  +: 4];
  assign f_rd  = instr[RD_LSB  +: REG_AW];
  assign f_rs1 = instr[RS1_LSB +: REG_AW];
  assign f_rs2 = instr[RS2_LSB +: REG_AW];

`ifdef ALU_SEQ_LOADI_EN
  assign is_loadi = (f_op == OP_LOADI);

  // LOADI bypasses the ALU, so the immediate and the write-source select are held locally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loadi_q <= 1'b0;
      imm_q   <= '0;
    end else if (accept) begin
      loadi_q <= is_loadi;
      imm_q   <= 4'({f_rs1, f_rs2});
    end
  end
`else
  assign is_loadi = 1'b0;
  assign loadi_q  = 1'b0;
  assign imm_q    = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (instr_valid) state_nxt = is_loadi ? ST_CAPTURE : ST_ISSUE;
      ST_ISSUE:   state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    in_capture  = 1'b0;
    unique case (state)
      ST_IDLE:    instr_ready = 1'b1;
      ST_CAPTURE: in_capture  = 1'b1;
      default:    ;
    endcase
  end

  assign accept   = instr_valid & instr_ready;
  assign rf_we    = in_capture & (loadi_q | alu_we);
  assign rf_wdata = loadi_q ? imm_q : alu_result;

  // Accept and capture occupy different states, so the two updates never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_IDLE;
      opnd1_q <= '0;
      opnd2_q <= '0;
      rd_q    <= '0;
      done_q  <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      done_q <= in_capture;
      if (accept) begin
        op_q    <= f_op;
        opnd1_q <= rdata1;
        opnd2_q <= rdata2;
        rd_q    <= f_rd;
      end else if (in_capture) begin
        op_q <= OP_IDLE;
        if (!loadi_q) begin
          z_q <= alu_zero;
          c_q <= alu_carry;
        end
      end
    end
  end

  alu_seq_regfile #(
    .AW (REG_AW)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we),
    .waddr    (rd_q),
    .wdata    (rf_wdata),
    .raddr1   (f_rs1),
    .rdata1   (rdata1),
    .raddr2   (f_rs2),
    .rdata2   (rdata2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  assign alu_op       = op_q;
  assign alu_operand1 = opnd1_q;
  assign alu_operand2 = opnd2_q;
  assign done         = done_q;
  assign z_flag       = z_q;
  assign c_flag       = c_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed vector table, hand-written
// back-to-back and mid-instruction reset sequences, and a randomized run against an instruction-level model.
module tb_alu_seq_ctrl;
  import alu_seq_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [9:0] instr;
  logic [3:0] alu_operand1, alu_operand2, alu_op;
  logic [3:0] alu_result;
  logic       alu_zero, alu_carry, alu_we;
  logic       done, z_flag, c_flag;
  logic [1:0] dbg_addr;
  logic [3:0] dbg_data;

  int checks = 0;
  int errors = 0;

  alu_seq_ctrl #(
    .REG_AW (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .alu_operand1 (alu_operand1),
    .alu_operand2 (alu_operand2),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_carry    (alu_carry),
    .alu_we       (alu_we),
    .done         (done),
    .z_flag       (z_flag),
    .c_flag       (c_flag),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] res;
    logic       z;
    logic       c;
    logic       we;
  } alu_t;

  // Behaviour of the 4-bit ALU this sequencer is paired with.
  function automatic alu_t alu_fn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    alu_t       r;
    logic [4:0] s;
    logic [7:0] p;
    r    = '0;
    r.we = 1'b1;
    case (op)
      4'd0:  begin s = {1'b0, a} + {1'b0, b}; r.res = s[3:0]; r.c = s[4]; end
      4'd1:  begin r.res = a - b; r.c = (a < b); end
      4'd2:  begin p = {4'b0, a} * {4'b0, b}; r.res = p[3:0]; r.c = (p[7:4] != 4'd0); end
      4'd3:  r.res = (b == 4'd0) ? 4'd0 : a / b;
      4'd4:  r.res = a & b;
      4'd5:  r.res = a | b;
      4'd6:  r.res = a ^ b;
      4'd7:  r.res = a ~^ b;
      4'd8:  r.res = ~a;
      4'd9:  begin r.res = {1'b0, a[3:1]}; r.c = a[0]; end
      4'd10: begin r.res = {a[2:0], 1'b0}; r.c = a[3]; end
      default: begin r.res = 4'd0; r.c = 1'b0; r.we = 1'b0; end
    endcase
    r.z = (r.res == 4'd0);
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) {alu_result, alu_zero, alu_carry, alu_we} <= '0;
    else        {alu_result, alu_zero, alu_carry, alu_we} <= alu_fn(alu_op, alu_operand1, alu_operand2);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_reg(input string name, input logic [1:0] idx, input logic [3:0] exp);
    dbg_addr = idx;
    #1;
    check(name, {4'd0, dbg_data}, {4'd0, exp});
  endtask

  function automatic logic [9:0] mk(input logic [3:0] op, input logic [1:0] rd,
                                    input logic [1:0] rs1, input logic [1:0] rs2);
    return {op, rd, rs1, rs2};
  endfunction

  task automatic do_reset();
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    dbg_addr    = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Offers one instruction, returns cycles from accept to done and how many of those had ready low.
  task automatic run_instr(input logic [9:0] ins, output int lat, output int low);
    int w;
    instr       = ins;
    instr_valid = 1'b1;
    w = 0;
    while (!instr_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1 instr_valid = 1'b0;
    lat = 0;
    low = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!instr_ready) low++;
    end while (!done && lat < 10);
  endtask

  typedef struct {
    logic [9:0] ins;
    logic [1:0] reg_idx;
    logic [3:0] reg_val;
    logic       z;
    logic       c;
    int         lat;
  } vec_t;

  vec_t       vecs[16];
  logic [3:0] m_regs[4];
  logic       m_z, m_c;

  initial begin
    int lat, low, exp_lat, pulses;
    logic [3:0] op;
    logic [1:0] rd, rs1, rs2;
    alu_t r;

    do_reset();

    // Reset state
    check("rst_ready", {7'd0, instr_ready}, 8'd1);
    check("rst_alu_op", {4'd0, alu_op}, 8'h0f);
    check("rst_opnd1", {4'd0, alu_operand1}, 8'd0);
    check("rst_opnd2", {4'd0, alu_operand2}, 8'd0);
    check("rst_done", {7'd0, done}, 8'd0);
    check("rst_flags", {6'd0, z_flag, c_flag}, 8'd0);
    for (int i = 0; i < 4; i++) check_reg("rst_reg", 2'(i), 4'd0);

    vecs[0]  = '{mk(OP_NOT, 2'd1, 2'd0, 2'd0), 2'd1, 4'hf, 1'b0, 1'b0, 3};
    vecs[1]  = '{mk(OP_SHR, 2'd1, 2'd1, 2'd0), 2'd1, 4'h7, 1'b0, 1'b1, 3};
    vecs[2]  = '{mk(OP_SHR, 2'd1, 2'd1, 2'd0), 2'd1, 4'h3, 1'b0, 1'b1, 3};
    vecs[3]  = '{mk(OP_SHR, 2'd1, 2'd1, 2'd0), 2'd1, 4'h1, 1'b0, 1'b1, 3};
    vecs[4]  = '{mk(OP_SHL, 2'd2, 2'd1, 2'd0), 2'd2, 4'h2, 1'b0, 1'b0, 3};
    vecs[5]  = '{mk(OP_SHL, 2'd2, 2'd2, 2'd0), 2'd2, 4'h4, 1'b0, 1'b0, 3};
    vecs[6]  = '{mk(OP_SHL, 2'd2, 2'd2, 2'd0), 2'd2, 4'h8, 1'b0, 1'b0, 3};
    vecs[7]  = '{mk(OP_ADD, 2'd1, 2'd1, 2'd2), 2'd1, 4'h9, 1'b0, 1'b0, 3};
    vecs[8]  = '{mk(OP_ADD, 2'd0, 2'd1, 2'd2), 2'd0, 4'h1, 1'b0, 1'b1, 3};
    vecs[9]  = '{mk(OP_DIV, 2'd0, 2'd1, 2'd3), 2'd0, 4'h0, 1'b1, 1'b0, 3};
    vecs[10] = '{mk(4'b1011, 2'd1, 2'd1, 2'd2), 2'd1, 4'h9, 1'b1, 1'b0, 3};
    vecs[11] = '{mk(OP_XOR, 2'd3, 2'd1, 2'd2), 2'd3, 4'h1, 1'b0, 1'b0, 3};
`ifdef ALU_SEQ_LOADI_EN
    vecs[12] = '{mk(4'b1111, 2'd2, 2'd1, 2'd3), 2'd2, 4'h7, 1'b0, 1'b0, 2};
    vecs[13] = '{mk(OP_SUB, 2'd3, 2'd1, 2'd1), 2'd3, 4'h0, 1'b1, 1'b0, 3};
    vecs[14] = '{mk(OP_MUL, 2'd3, 2'd1, 2'd2), 2'd3, 4'hf, 1'b0, 1'b1, 3};
    vecs[15] = '{mk(OP_SUB, 2'd0, 2'd2, 2'd1), 2'd0, 4'he, 1'b0, 1'b1, 3};
`else
    vecs[12] = '{mk(4'b1111, 2'd2, 2'd1, 2'd3), 2'd2, 4'h8, 1'b1, 1'b0, 3};
    vecs[13] = '{mk(OP_SUB, 2'd3, 2'd1, 2'd1), 2'd3, 4'h0, 1'b1, 1'b0, 3};
    vecs[14] = '{mk(OP_MUL, 2'd3, 2'd1, 2'd2), 2'd3, 4'h8, 1'b0, 1'b1, 3};
    vecs[15] = '{mk(OP_SUB, 2'd0, 2'd2, 2'd1), 2'd0, 4'hf, 1'b0, 1'b1, 3};
`endif

    for (int i = 0; i < 16; i++) begin
      run_instr(vecs[i].ins, lat, low);
      check($sformatf("vec%0d_latency", i), 8'(lat), 8'(vecs[i].lat));
      check($sformatf("vec%0d_ready_low", i), 8'(low), 8'(vecs[i].lat - 1));
      check($sformatf("vec%0d_alu_op_idle", i), {4'd0, alu_op}, 8'h0f);
      check($sformatf("vec%0d_z", i), {7'd0, z_flag}, {7'd0, vecs[i].z});
      check($sformatf("vec%0d_c", i), {7'd0, c_flag}, {7'd0, vecs[i].c});
      check_reg($sformatf("vec%0d_reg", i), vecs[i].reg_idx, vecs[i].reg_val);
    end

    // Back-to-back: second instruction accepted in the done cycle reads the first's result.
    instr       = mk(OP_ADD, 2'd3, 2'd1, 2'd1);
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr = mk(OP_ADD, 2'd0, 2'd3, 2'd3);
    low = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (!instr_ready) low++;
    end
    @(negedge clk);
    check("b2b_first_done", {7'd0, done}, 8'd1);
    check("b2b_ready_in_done", {7'd0, instr_ready}, 8'd1);
    check_reg("b2b_first_reg", 2'd3, 4'h2);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!instr_ready) low++;
    end while (!done && lat < 10);
    check("b2b_second_latency", 8'(lat), 8'd3);
    check("b2b_ready_low_total", 8'(low), 8'd4);
    check_reg("b2b_second_reg", 2'd0, 4'h4);

    // Reset asserted during CAPTURE of MUL r2,r1,r1.
    instr       = mk(OP_MUL, 2'd2, 2'd1, 2'd1);
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_ready_in_capture", {7'd0, instr_ready}, 8'd0);
    rst_n = 1'b0;
    #1;
    check("abort_alu_op", {4'd0, alu_op}, 8'h0f);
    check("abort_ready", {7'd0, instr_ready}, 8'd1);
    check("abort_opnd1", {4'd0, alu_operand1}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort_no_done", 8'(pulses), 8'd0);
    check_reg("abort_r2", 2'd2, 4'd0);
    check_reg("abort_r1", 2'd1, 4'd0);
    check("abort_flags", {6'd0, z_flag, c_flag}, 8'd0);

    // Randomized run against an instruction-level model.
    for (int i = 0; i < 4; i++) m_regs[i] = 4'd0;
    m_z = 1'b0;
    m_c = 1'b0;
    for (int n = 0; n < 80; n++) begin
      op  = 4'($urandom_range(0, 15));
      rd  = 2'($urandom_range(0, 3));
      rs1 = 2'($urandom_range(0, 3));
      rs2 = 2'($urandom_range(0, 3));
      pulses = 0;
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        if (done) pulses++;
      end
      if (pulses != 0) check("rnd_done_single_pulse", 8'(pulses), 8'd0);
      exp_lat = 3;
`ifdef ALU_SEQ_LOADI_EN
      if (op == 4'hf) begin
        m_regs[rd] = {rs1, rs2};
        exp_lat    = 2;
      end else begin
        r = alu_fn(op, m_regs[rs1], m_regs[rs2]);
        if (r.we) m_regs[rd] = r.res;
        m_z = r.z;
        m_c = r.c;
      end
`else
      r = alu_fn(op, m_regs[rs1], m_regs[rs2]);
      if (r.we) m_regs[rd] = r.res;
      m_z = r.z;
      m_c = r.c;
`endif
      run_instr(mk(op, rd, rs1, rs2), lat, low);
      check("rnd_latency", 8'(lat), 8'(exp_lat));
      check("rnd_z", {7'd0, z_flag}, {7'd0, m_z});
      check("rnd_c", {7'd0, c_flag}, {7'd0, m_c});
      for (int i = 0; i < 4; i++) check_reg("rnd_reg", 2'(i), m_regs[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
